// File: rtl/x_count_scheduler.sv
// -----------------------------------------------------------------------------
// x_count_scheduler
//   Round-robin scheduler that shares one external 4-state x-pulse counter
//   among NREQ requesters. The winner gets the grant. The counter is cleared
//   for one cycle, and then the owner's x strobe is routed to it. When the
//   counter raises its terminal flag (cnt_y), the owner receives a one-cycle
//   done pulse. A per-tenure cycle limit forces a release when an owner stalls.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req          per-requester level request, held until done/abort
//   x_in         per-requester event strobe
//   cnt_y        terminal flag from the shared counter
//   cnt_x        owner's strobe, forwarded to the counter (RUN only)
//   cnt_clr      synchronous clear to the shared counter
//   gnt          one-hot grant, zero when idle
//   done         one-cycle completion pulse to the owner
//   busy         high in every state except IDLE
//   timeout_err  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module x_count_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] x_in,
  input  logic            cnt_y,
  output logic            cnt_x,
  output logic            cnt_clr,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            timeout_err
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]   TMR_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [TW-1:0]   tmr;
  logic [OW-1:0]   pick;

  // Round-robin search starting just after the current owner. The loop runs
  // from the farthest candidate to the nearest, so the nearest requester
  // overwrites the others and wins. This puts the requester just served last.
  // NOTE: 'pick' gets a default before the loop so that no path leaves it
  // unassigned; without that default, a latch would be inferred.
  always_comb begin
    pick = owner;
    for (int i = NREQ; i >= 1; i--) begin
      int idx;
      idx = (int'(owner) + i) % NREQ;
      if (req[OW'(idx)]) pick = OW'(idx);
    end
  end

  // The strobe mux is the only combinational output. It must follow x_in in the
  // same cycle so that the counter sees each owner pulse exactly once.
  assign cnt_x = (state == S_RUN) ? x_in[owner] : 1'b0;

  // State, owner, timer and all remaining outputs are updated together. Each
  // output therefore describes the state that is entered at the same edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before the edge.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous. It is sampled on the clock edge like any
    // other input, so it does not appear in the sensitivity list.
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OW'(NREQ - 1);
      tmr         <= '0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      cnt_clr     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on their transitions.
      done        <= '0;
      cnt_clr     <= 1'b0;
      timeout_err <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (|req) begin
            owner   <= pick;
            gnt     <= ONE << pick;
            busy    <= 1'b1;
            cnt_clr <= 1'b1;
            state   <= S_CLR;
          end
        end

        // cnt_y is ignored here because the counter is being cleared.
        S_CLR: begin
          tmr   <= '0;
          state <= S_RUN;
        end

        // Completion takes priority over abort and timeout. A requester that
        // finishes in its last allowed cycle therefore still gets its done.
        S_RUN: begin
          tmr <= tmr + 1'b1;
          if (cnt_y) begin
            done  <= gnt;
            state <= S_DONE;
          end else if (!req[owner]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmr == TMR_END) begin
            gnt         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end

        S_DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_count_scheduler.sv
// -----------------------------------------------------------------------------
// tb_x_count_scheduler
//   Bench for x_count_scheduler. It contains a behavioural model of the shared
//   4-state counter, which the DUT drives through cnt_clr/cnt_x and which feeds
//   cnt_y back. It also contains an independent model of the scheduling rules.
//   Each scenario task drives stimulus and compares the DUT against the model
//   and against directed expectations.
// -----------------------------------------------------------------------------
module tb_x_count_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int VW      = 2 * NREQ + 6;

  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] x_in;
  logic            cnt_y;
  logic            cnt_x;
  logic            cnt_clr;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  x_count_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .cnt_y(cnt_y),
    .cnt_x(cnt_x), .cnt_clr(cnt_clr), .gnt(gnt), .done(done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // The shared counter holds the states A..D as 0..3. y is high in D, and D
  // holds until the next clear. The counter is not tied to rst.
  logic [1:0] cnt_state = 2'd0;
  always @(posedge clk) begin
    if (cnt_clr === 1'b1)                          cnt_state <= 2'd0;
    else if (cnt_x === 1'b1 && cnt_state != 2'd3)  cnt_state <= cnt_state + 2'd1;
  end
  assign cnt_y = (cnt_state == 2'd3);

  // ---------------------------------------------------------------------------
  // Reference model: the tenure phase, the owner, RUN cycles used, a pending
  // timeout flag, and the number of owner pulses the counter should hold.
  // ---------------------------------------------------------------------------
  int m_phase = P_IDLE;
  int m_owner = NREQ - 1;
  int m_runs  = 0;
  bit m_terr  = 1'b0;
  int m_cnt   = 0;

  function automatic int next_owner(int cur, logic [NREQ-1:0] r);
    int k;
    k = (cur + 1) % NREQ;
    for (int n = 0; n < NREQ; n++) begin
      if (r[k]) return k;
      k = (k + 1) % NREQ;
    end
    return cur;
  endfunction

  always @(posedge clk) begin
    if (m_phase == P_CLR) m_cnt <= 0;
    else if (m_phase == P_RUN && x_in[m_owner] && m_cnt < 3) m_cnt <= m_cnt + 1;

    if (rst) begin
      m_phase <= P_IDLE;
      m_owner <= NREQ - 1;
      m_runs  <= 0;
      m_terr  <= 1'b0;
    end else begin
      m_terr <= 1'b0;
      if (m_phase == P_IDLE) begin
        if (req != '0) begin
          m_owner <= next_owner(m_owner, req);
          m_phase <= P_CLR;
        end
      end else if (m_phase == P_CLR) begin
        m_runs  <= 0;
        m_phase <= P_RUN;
      end else if (m_phase == P_RUN) begin
        m_runs <= m_runs + 1;
        if (m_cnt == 3)                m_phase <= P_DONE;
        else if (!req[m_owner])        m_phase <= P_IDLE;
        else if (m_runs + 1 == TIMEOUT) begin
          m_phase <= P_IDLE;
          m_terr  <= 1'b1;
        end
      end else begin
        m_phase <= P_IDLE;
      end
    end
  end

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] g, d;
    logic            cx;
    g  = (m_phase != P_IDLE) ? onehot(m_owner) : '0;
    d  = (m_phase == P_DONE) ? onehot(m_owner) : '0;
    cx = (m_phase == P_RUN) ? x_in[m_owner] : 1'b0;
    return {g, d, (m_phase != P_IDLE), (m_phase == P_CLR), m_terr, cx, 2'(m_cnt)};
  endfunction

  wire [VW-1:0] dut_vec = {gnt, done, busy, cnt_clr, timeout_err, cnt_x, cnt_state};

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    x_in = '1;
    cyc();
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy, cnt_clr, timeout_err, cnt_x} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: dut=%h required=0",
               {gnt, done, busy, cnt_clr, timeout_err, cnt_x});
    end
    cyc();
    rst  = 1'b0;
    x_in = '0;
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: dut=%h model=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic go_idle(string tag);
    bit ok;
    ok   = 1'b0;
    req  = '0;
    x_in = '0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s_drain: dut=%h model=%h", tag, dut_vec, exp_vec());
      end
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b required=0", tag, busy);
    end
  endtask

  // Single requester: three owner pulses, then completion.
  task automatic test_single();
    cyc();
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_no_gnt_yet: gnt=%b required=0000", gnt);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, cnt_clr} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_clr: gnt=%b clr=%b required 0001/1", gnt, cnt_clr);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      x_in = 4'b0001;
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_run%0d: dut=%h model=%h", k, dut_vec, exp_vec());
      end
    end
    cyc();
    x_in = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, cnt_y} !== {4'b0001, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL single_y_seen: gnt=%b done=%b y=%b required 0001/0000/1", gnt, done, cnt_y);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, done} !== {4'b0001, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_done: gnt=%b done=%b required 0001/0001", gnt, done);
    end
    cyc();
    req = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy} !== '0) begin
      n_fail++;
      $display("FAIL single_after: gnt=%b done=%b busy=%b required 0", gnt, done, busy);
    end
  endtask

  // Two requesters held: the tenures alternate, with exactly one IDLE cycle between them.
  task automatic test_back_to_back();
    int  prev_owner, cur, tenures;
    bit  prev_busy, gap_pending;
    prev_owner  = -1;
    tenures     = 0;
    prev_busy   = 1'b0;
    gap_pending = 1'b0;
    cyc();
    req = 4'b0011;
    for (int i = 0; i < 100; i++) begin
      cyc();
      x_in = NREQ'($urandom) & NREQ'($urandom);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_model: dut=%h model=%h", dut_vec, exp_vec());
      end
      n_cmp++;
      if (gnt === 4'b0011) begin
        n_fail++;
        $display("FAIL b2b_gnt_both: gnt=%b required one-hot", gnt);
      end
      if (gap_pending) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap: busy=%b required 1 after one idle cycle", busy);
        end
        gap_pending = 1'b0;
      end
      if (prev_busy && busy === 1'b0) gap_pending = 1'b1;
      prev_busy = (busy === 1'b1);
      if (cnt_clr === 1'b1) begin
        cur = (gnt === 4'b0010) ? 1 : 0;
        tenures++;
        if (prev_owner >= 0) begin
          n_cmp++;
          if (cur !== 1 - prev_owner) begin
            n_fail++;
            $display("FAIL b2b_alternate: owner=%0d required=%0d", cur, 1 - prev_owner);
          end
        end
        prev_owner = cur;
      end
    end
    n_cmp++;
    if (tenures < 5) begin
      n_fail++;
      $display("FAIL b2b_tenures: count=%0d required>=5", tenures);
    end
    go_idle("b2b");
  endtask

  // A stalled owner is released after TIMEOUT RUN cycles.
  task automatic test_timeout();
    int run_cnt;
    bit saw_done;
    run_cnt  = 0;
    saw_done = 1'b0;
    cyc();
    req  = 4'b0100;
    x_in = '0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, cnt_clr} !== {4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_clr: gnt=%b clr=%b required 0100/1", gnt, cnt_clr);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout_model: dut=%h model=%h", dut_vec, exp_vec());
      end
      if (gnt === 4'b0000) break;
      run_cnt++;
      if (done !== 4'b0000) saw_done = 1'b1;
    end
    n_cmp++;
    if ({run_cnt, timeout_err, saw_done} !== {TIMEOUT, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_release: run=%0d terr=%b done_seen=%b required %0d/1/0",
               run_cnt, timeout_err, saw_done, TIMEOUT);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: terr=%b required 0", timeout_err);
    end
    go_idle("timeout");
  endtask

  // An abort releases without done; cnt_y together with a req drop gives done.
  task automatic test_abort();
    cyc();
    req = 4'b0001;
    @(negedge clk);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
    end
    cyc();
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_still_run: gnt=%b required 0001", gnt);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL abort_release: gnt=%b done=%b terr=%b required 0", gnt, done, timeout_err);
    end
    cyc();
    req = 4'b0001;
    @(negedge clk);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cyc();
      x_in = 4'b0001;
      @(negedge clk);
    end
    cyc();
    x_in = '0;
    req  = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, cnt_y} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_y_and_drop: gnt=%b y=%b required 0001/1", gnt, cnt_y);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({done, timeout_err} !== {4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_done_wins: done=%b terr=%b required 0001/0", done, timeout_err);
    end
    go_idle("abort");
  endtask

  // Reset in mid-tenure; afterwards requester 0 is served first.
  task automatic test_reset_mid();
    cyc();
    req  = 4'b1111;
    x_in = 4'b1111;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy, cnt_clr, timeout_err, cnt_x} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: dut=%h required=0",
               {gnt, done, busy, cnt_clr, timeout_err, cnt_x});
    end
    cyc();
    rst  = 1'b0;
    x_in = '0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt, cnt_clr} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_first_owner: gnt=%b clr=%b required 0001/1", gnt, cnt_clr);
    end
    go_idle("rstmid");
  endtask

  // Strobes from non-owners never reach the counter.
  task automatic test_x_isolation();
    cyc();
    req = 4'b0010;
    @(negedge clk);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      cyc();
      x_in = NREQ'($urandom) & 4'b1101;
      @(negedge clk);
      n_cmp++;
      if ({cnt_x, cnt_state} !== 3'b000) begin
        n_fail++;
        $display("FAIL xiso_noise: cnt_x=%b count=%0d required 0/0", cnt_x, cnt_state);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      x_in = (NREQ'($urandom) & 4'b1101) | 4'b0010;
      @(negedge clk);
      n_cmp++;
      if (cnt_x !== 1'b1) begin
        n_fail++;
        $display("FAIL xiso_owner: cnt_x=%b required 1", cnt_x);
      end
    end
    cyc();
    x_in = NREQ'($urandom) & 4'b1101;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++;
    if (done !== 4'b0010) begin
      n_fail++;
      $display("FAIL xiso_done: done=%b required 0010", done);
    end
    go_idle("xiso");
  endtask

  // Random traffic checked cycle by cycle against the model.
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cyc();
      if ($urandom_range(7) == 0) req = NREQ'($urandom);
      x_in = NREQ'($urandom) & NREQ'($urandom);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_c%0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      n_cmp++;
      if (((gnt & (gnt - 1'b1)) !== '0) || ((done & ~gnt) !== '0)) begin
        n_fail++;
        $display("FAIL random_onehot: gnt=%b done=%b required one-hot, done within gnt", gnt, done);
      end
    end
    go_idle("random");
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    x_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_x_isolation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
